// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux select-path scan sequencer.
// Select width and input count match the downstream 8:1 gate-level select stage.
package mux_scan_pkg;

    localparam int SEL_W        = 3;
    localparam int NUM_IN       = 8;
    localparam int STEP_CNT_W   = 4;
    localparam int STEP_DIV_MAX = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic is_last_sel(input sel_t s);
        return s == sel_t'(NUM_IN - 1);
    endfunction

endpackage

// File: rtl/step_timer.sv
// STEP_DIV-modulo step counter: tick is combinational on the last count while enabled.
// Counter self-clears on tick; clr has priority and restarts the count from 0.
module step_timer
    import mux_scan_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [STEP_CNT_W-1:0] CNT_MAX = STEP_CNT_W'(STEP_DIV - 1);

    logic [STEP_CNT_W-1:0] cnt_q;
    logic [STEP_CNT_W-1:0] cnt_d;

    assign tick = en && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    step_div_legal: assert property (@(posedge clk) (STEP_DIV >= 1 && STEP_DIV <= STEP_DIV_MAX))
        else $error("step_timer: STEP_DIV must be within 1..16");

endmodule

// File: rtl/mux_scan_seq.sv
// Loads a word, walks {p,q,r} through 0..7 holding each index STEP_DIV cycles, streams sampled f.
// One word per 8*STEP_DIV+1 cycles; load_ready only in IDLE, load_valid ignored while scanning.
module mux_scan_seq
    import mux_scan_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_valid,
    input  logic [NUM_IN-1:0]   load_data,
    output logic                load_ready,
    output logic [NUM_IN-1:0]   a,
    output logic                p,
    output logic                q,
    output logic                r,
    input  logic                f,
    output logic                ser_bit,
    output logic                ser_valid,
    output logic                ser_last,
    output logic                done,
    output logic                mismatch
);

    state_e              state_q, state_d;
    sel_t                sel_q, sel_d;
    logic [NUM_IN-1:0]   a_q, a_d;
    logic                ser_bit_q, ser_bit_d;
    logic                ser_valid_q, ser_valid_d;
    logic                ser_last_q, ser_last_d;
    logic                done_q, done_d;
    logic                mismatch_q, mismatch_d;

    logic                accept;
    logic                step_tick;

    assign accept = load_valid && (state_q == IDLE);

    step_timer #(
        .STEP_DIV (STEP_DIV)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == SCAN),
        .clr   (accept),
        .tick  (step_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        a_d         = a_q;
        ser_bit_d   = ser_bit_q;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
        done_d      = 1'b0;
        mismatch_d  = mismatch_q;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    a_d        = load_data;
                    sel_d      = '0;
                    mismatch_d = 1'b0;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (step_tick) begin
                    ser_bit_d   = f;
                    ser_valid_d = 1'b1;
                    // Sticky self-check: the mux must return the bit we drove at this index.
                    if (f != a_q[sel_q]) begin
                        mismatch_d = 1'b1;
                    end
                    if (is_last_sel(sel_q)) begin
                        ser_last_d = 1'b1;
                        done_d     = 1'b1;
                        sel_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        sel_d = sel_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q       <= '0;
            a_q         <= '0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            a_q         <= a_d;
            ser_bit_q   <= ser_bit_d;
            ser_valid_q <= ser_valid_d;
            ser_last_q  <= ser_last_d;
            done_q      <= done_d;
            mismatch_q  <= mismatch_d;
        end
    end

    // sel only leaves 0 in SCAN, so driving it straight out keeps {p,q,r}=0 in IDLE.
    assign load_ready = (state_q == IDLE);
    assign a          = a_q;
    assign p          = sel_q[2];
    assign q          = sel_q[1];
    assign r          = sel_q[0];
    assign ser_bit    = ser_bit_q;
    assign ser_valid  = ser_valid_q;
    assign ser_last   = ser_last_q;
    assign done       = done_q;
    assign mismatch   = mismatch_q;

endmodule

// File: doc/mux_scan_seq.md
# mux_scan_seq

Sequencer that sits directly upstream of the team's 8:1 gate-level select stage. It accepts an 8-bit word on a valid/ready handshake, drives the word onto the mux data lines `a0..a7`, and steps the select lines `p,q,r` through 0..7. It samples the mux output `f` on each step and emits it as a framed serial stream. It also flags any sampled bit that differs from the loaded word, which gives a built-in self-check of the select path.

## Interface
Parameters:
- STEP_DIV, default 1: clock cycles each select index is held before `f` is sampled. Legal range 1..16; 0 is illegal and is flagged by a simulation assertion.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_valid  in  1  upstream word available
- load_data  in  8  word; bit i drives mux input ai
- load_ready  out  1  block can accept a word; equals state==IDLE
- a  out  8  registered data word to mux; a[i] -> ai
- p  out  1  select MSB
- q  out  1  select middle bit
- r  out  1  select LSB
- f  in  1  mux output, fed back for sampling
- ser_bit  out  1  sampled mux output
- ser_valid  out  1  one-cycle strobe, ser_bit valid
- ser_last  out  1  high with the ser_valid of index 7
- done  out  1  one-cycle pulse, coincident with ser_last
- mismatch  out  1  sticky: some sampled bit differed from a[index]

## Operation
- States: IDLE, SCAN.
- IDLE: load_ready=1; {p,q,r}=0; a holds the last word.
- Accept on the edge where load_valid && load_ready:
  - a <= load_data
  - sel <= 0
  - step counter <= 0
  - mismatch <= 0
  - state <= SCAN
- SCAN: {p,q,r}=sel (p MSB). The step counter runs 0..STEP_DIV-1. On the edge where it equals STEP_DIV-1 (the step tick):
  - ser_bit <= f
  - ser_valid <= 1
  - if f != a[sel]: mismatch <= 1
  - if sel==7: ser_last <= 1, done <= 1, sel <= 0, state <= IDLE
  - otherwise: sel <= sel+1, counter <= 0
- ser_valid, ser_last and done are registered and deassert on the next edge unless re-set.
- Sel wraps only through the return to IDLE. It never counts past 7.
- load_valid is ignored in SCAN, and load_data may change freely while scanning.
- mismatch clears only on the next accept or on reset.

## Timing
- Reset values (rst_n low, asynchronous):
  - state=IDLE, load_ready=1
  - a=0, {p,q,r}=0
  - ser_bit=0, ser_valid=0, ser_last=0, done=0, mismatch=0
  - internal counters 0
- Reset mid-scan aborts immediately. No ser_last or done is emitted for the aborted word.
- Let E0 be the accept edge and D=STEP_DIV. Index k is driven on {p,q,r} from E0+k·D to E0+(k+1)·D.
- `f` is sampled at E0+(k+1)·D, and ser_valid is high for the cycle following that edge.
- Index 7 is sampled at E0+8D, together with ser_last/done and the return to IDLE.
- The earliest next accept is edge E0+8D+1, so throughput is one word per 8D+1 cycles.
- The mux path is combinational: f must settle within one cycle of the {p,q,r}/a change. D>1 gives margin.

## Structure
- Package `mux_scan_pkg`:
  - state enum {IDLE, SCAN}
  - SEL_W=3
  - NUM_IN=8
  - STEP_CNT_W=4
- One sub-module, `step_timer`: a STEP_DIV-modulo counter with clear input and a `tick` output. `mux_scan_seq` holds the FSM, sel, data register and output flops.

## Test plan
- Reset, then idle: after rst_n rises, load_ready=1, {p,q,r}=0, and ser_valid stays 0 for 20 cycles.
- D=1, load_data=8'hA5, f driven by the real 8:1 mux:
  - ser_bit sequence over 8 strobes = 1,0,1,0,0,1,0,1 (a0 first)
  - ser_last/done on the 8th strobe at E0+8
  - mismatch=0
  - load_ready high again at E0+8
- D=4, load_data=8'h3C:
  - each {p,q,r} value held 4 cycles
  - strobes at E0+4, 8, …, 32
  - bits 0,0,1,1,1,1,0,0
- Fault injection: force f to 0 throughout, load 8'h01 → mismatch sets after the first strobe and stays 1 through done. A following load of 8'h00 clears it and it stays 0.
- Reset mid-operation and back-to-back:
  - rst_n pulsed low at E0+3 → all outputs at reset values, no done
  - next, load_valid held high continuously → accepts at E0, E0+9 and E0+18 with D=1; load_data changes during SCAN do not alter a
